fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_if_id_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM state
//   encoding, default reset PC and bubble instruction, and the small address
//   helpers used by the PC logic.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  // RUN       : fetching sequentially
  // HOLD      : decode asked us to freeze, no redirect waiting
  // HOLD_PEND : frozen, and a redirect arrived that must be applied on release
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_HOLD_PEND = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0064;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Instruction addresses are word aligned; the low two bits of any incoming
  // target are discarded rather than trapped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Holds the fetched instruction, its PC+4 and a
//   valid flag. Control priority: reset > flush > load > hold.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset (loads a bubble)
//   load_i   : capture inst_i / pc4_i as a valid fetch
//   flush_i  : replace contents with a bubble (NOP_INST, pc4 = 0, valid = 0)
//   inst_i   : instruction word from instruction memory
//   pc4_i    : PC+4 of that instruction
//   inst_o   : registered instruction
//   pc4_o    : registered PC+4
//   valid_o  : 1 = real fetch, 0 = bubble
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, the RUN/HOLD/HOLD_PEND FSM, the
//   pending redirect target and the committed-fetch counter; the IF/ID
//   register lives in if_id_reg.
//
// Ports
//   clk             : clock, rising edge
//   reset           : synchronous active-high reset
//   stall           : hazard hold from decode (freezes PC and IF/ID)
//   redirect        : taken branch/jump resolved downstream
//   redirect_target : byte address of the redirect destination
//   imem_addr       : current PC to instruction memory
//   imem_inst       : instruction returned combinationally by memory
//   if_id_inst      : registered instruction to decode
//   if_id_pc4       : registered PC+4 of that instruction
//   if_id_valid     : 1 = real fetch, 0 = bubble
//   fetch_count     : number of instructions committed into IF/ID
//
// Priority on every edge: reset > redirect > stall > advance.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic [31:0]  count_q, count_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  target_aligned;
  logic         ifid_load;
  logic         ifid_flush;

  assign pc_plus4       = pc_q + PC_STEP;
  assign target_aligned = word_align(redirect_target);

  // IF/ID control. A bubble is inserted either by an immediate redirect or by
  // applying a redirect that was parked while stalled.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (redirect && !stall) begin
      ifid_flush = 1'b1;
    end else if (!redirect && !stall) begin
      if (state_q == ST_HOLD_PEND) begin
        ifid_flush = 1'b1;
      end else begin
        ifid_load = 1'b1;
      end
    end
  end

  // Next-state logic for PC, FSM, pending target and counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    count_d       = count_q;

    if (redirect && !stall) begin
      // Immediate redirect also cancels anything parked earlier.
      pc_d          = target_aligned;
      pend_target_d = 32'd0;
      state_d       = ST_RUN;
    end else if (redirect && stall) begin
      // Park the target; a later redirect while still stalled overwrites it.
      pend_target_d = target_aligned;
      state_d       = ST_HOLD_PEND;
    end else if (stall) begin
      // A parked redirect must survive a plain stall, so only RUN moves.
      if (state_q == ST_RUN) begin
        state_d = ST_HOLD;
      end
    end else begin
      unique case (state_q)
        ST_RUN, ST_HOLD: begin
          pc_d    = pc_plus4;
          count_d = count_q + 32'd1;
          state_d = ST_RUN;
        end
        ST_HOLD_PEND: begin
          pc_d          = pend_target_q;
          pend_target_d = 32'd0;
          state_d       = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'd0;
      count_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      count_q       <= count_d;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .inst_i  (imem_inst),
    .pc4_i   (pc_plus4),
    .inst_o  (if_id_inst),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed stimulus for fetch_unit with a behavioural reference model and a
//   per-cycle comparator, plus literal checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .if_id_inst      (if_id_inst),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  // ---------------- reference model ----------------
  // The model only tracks whether a redirect is parked; RUN and HOLD are
  // indistinguishable from the outside.
  bit          m_init  = 1'b0;
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt, m_pend_t;
  bit          m_valid, m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_init  = 1'b1;
      m_pc    = 32'h64;
      m_inst  = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      m_cnt   = 32'h0;
      m_pend  = 1'b0;
    end else if (m_init) begin
      if (redirect && !stall) begin
        m_pc    = redirect_target & 32'hFFFF_FFFC;
        m_inst  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_pend  = 1'b0;
      end else if (redirect) begin
        m_pend   = 1'b1;
        m_pend_t = redirect_target & 32'hFFFF_FFFC;
      end else if (stall) begin
        // nothing moves
      end else if (m_pend) begin
        m_pc    = m_pend_t;
        m_inst  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_pend  = 1'b0;
      end else begin
        m_inst  = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparator against the model.
  always @(negedge clk) begin
    if (m_init) begin
      check("model.imem_addr",   imem_addr,   m_pc);
      check("model.if_id_inst",  if_id_inst,  m_inst);
      check("model.if_id_pc4",   if_id_pc4,   m_pc4);
      check("model.if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("model.fetch_count", fetch_count, m_cnt);
    end
  end

  // One edge with the given controls; returns at the following falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    @(posedge clk);
    @(negedge clk);
    $display("step stall=%0b redirect=%0b tgt=%08h -> addr=%08h inst=%08h pc4=%08h v=%0b cnt=%0d",
             st, rd, tgt, imem_addr, if_id_inst, if_id_pc4, if_id_valid, fetch_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    @(negedge clk);
    // Redirect while reset is high must be ignored.
    step(1'b0, 1'b1, 32'h0000_0200);
    check("reset.addr",  imem_addr,   32'h64);
    check("reset.valid", {31'd0, if_id_valid}, 32'd0);
    check("reset.count", fetch_count, 32'd0);
    check("reset.pc4",   if_id_pc4,   32'd0);
    reset = 1'b0;

    // Free running fetch.
    step(1'b0, 1'b0, 32'h0);
    check("free1.addr", imem_addr, 32'h68);
    check("free1.pc4",  if_id_pc4, 32'h68);
    check("free1.inst", if_id_inst, mem_word(32'h64));
    check("free1.cnt",  fetch_count, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    check("free2.addr", imem_addr, 32'h6C);

    // Stall three cycles at 0x6C.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stall.addr", imem_addr, 32'h6C);
      check("stall.pc4",  if_id_pc4, 32'h6C);
      check("stall.cnt",  fetch_count, 32'd2);
    end
    step(1'b0, 1'b0, 32'h0);
    check("release.addr", imem_addr, 32'h70);
    check("release.cnt",  fetch_count, 32'd3);

    // Immediate redirect with misaligned target.
    step(1'b0, 1'b1, 32'h0000_0067);
    check("redir.addr",  imem_addr, 32'h64);
    check("redir.valid", {31'd0, if_id_valid}, 32'd0);
    check("redir.inst",  if_id_inst, 32'h0);
    check("redir.cnt",   fetch_count, 32'd3);
    step(1'b0, 1'b0, 32'h0);
    check("redir2.addr", imem_addr, 32'h68);

    // Redirects while stalled: newest target wins.
    step(1'b1, 1'b1, 32'h0000_0080);
    step(1'b1, 1'b1, 32'h0000_0090);
    check("pend.addr", imem_addr, 32'h68);
    step(1'b0, 1'b0, 32'h0);
    check("pend.apply",  imem_addr, 32'h90);
    check("pend.bubble", {31'd0, if_id_valid}, 32'd0);
    check("pend.cnt",    fetch_count, 32'd4);
    step(1'b0, 1'b0, 32'h0);
    check("pend.inst", if_id_inst, mem_word(32'h90));
    check("pend.pc4",  if_id_pc4, 32'h94);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    check("wrap.set", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("wrap.addr", imem_addr, 32'h0);
    check("wrap.pc4",  if_id_pc4, 32'h0);
    check("wrap.valid", {31'd0, if_id_valid}, 32'd1);

    // Reset while a redirect is parked.
    step(1'b1, 1'b1, 32'h0000_0080);
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    reset = 1'b0;
    check("rstpend.addr",  imem_addr, 32'h64);
    check("rstpend.valid", {31'd0, if_id_valid}, 32'd0);
    check("rstpend.cnt",   fetch_count, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check("rstpend.next", imem_addr, 32'h68);

    // Mixed control patterns checked by the model only.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           $urandom_range(0, 1023));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
